// File: rtl/adc_sample_unpack.sv
// Rebuilds 32-bit capture words from a little-endian byte stream and emits the
// three 10-bit ADC samples of each word on a valid/ready port with a trigger marker.
module adc_sample_unpack #(
  parameter int         COUNT_W  = 32,
  parameter logic [1:0] TAG_NONE = 2'b11
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               sync_i,
  input  logic               drop_pretrig_i,
  input  logic [7:0]         byte_i,
  input  logic               byte_valid_i,
  output logic               byte_ready_o,
  output logic [9:0]         sample_o,
  output logic               sample_valid_o,
  input  logic               sample_ready_i,
  output logic               sample_trig_o,
  output logic [COUNT_W-1:0] sample_count_o,
  output logic               tag_err_o
);

  logic [1:0]  byte_cnt_reg;
  logic [23:0] partial_reg;
  logic [29:0] word_reg;
  logic [1:0]  idx_reg;
  logic        trig_word_reg;
  logic [1:0]  word_tag_reg;
  logic        trig_seen_reg;
  logic [1:0]  trig_tag_reg;

  logic       sample_hs;
  logic       last_hs;
  logic       byte_hs;
  logic       word_done;
  logic       load_word;
  logic       new_trig;
  logic [1:0] in_tag;
  logic [1:0] idx_next;

  assign sample_hs = sample_valid_o & sample_ready_i;
  assign last_hs   = sample_hs & (idx_reg == 2'd2);
  // The final byte of a word may enter in the same cycle the stage drains.
  assign byte_ready_o = !sync_i & ((byte_cnt_reg != 2'd3) | !sample_valid_o | last_hs);
  assign byte_hs   = byte_valid_i & byte_ready_o;
  assign in_tag    = byte_i[7:6];
  assign word_done = byte_hs & (byte_cnt_reg == 2'd3);
  assign load_word = word_done & !(drop_pretrig_i & (in_tag == TAG_NONE));
  assign new_trig  = (in_tag != TAG_NONE) & !trig_seen_reg;
  assign idx_next  = idx_reg + 2'd1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      byte_cnt_reg   <= '0;
      partial_reg    <= '0;
      word_reg       <= '0;
      idx_reg        <= '0;
      trig_word_reg  <= 1'b0;
      word_tag_reg   <= TAG_NONE;
      trig_seen_reg  <= 1'b0;
      trig_tag_reg   <= TAG_NONE;
      sample_o       <= '0;
      sample_valid_o <= 1'b0;
      sample_trig_o  <= 1'b0;
      sample_count_o <= '0;
      tag_err_o      <= 1'b0;
    end else if (sync_i) begin
      byte_cnt_reg   <= '0;
      partial_reg    <= '0;
      word_reg       <= '0;
      idx_reg        <= '0;
      trig_word_reg  <= 1'b0;
      word_tag_reg   <= TAG_NONE;
      trig_seen_reg  <= 1'b0;
      trig_tag_reg   <= TAG_NONE;
      sample_o       <= '0;
      sample_valid_o <= 1'b0;
      sample_trig_o  <= 1'b0;
      sample_count_o <= '0;
      tag_err_o      <= 1'b0;
    end else begin
      if (byte_hs) begin
        case (byte_cnt_reg)
          2'd0:    partial_reg[7:0]   <= byte_i;
          2'd1:    partial_reg[15:8]  <= byte_i;
          2'd2:    partial_reg[23:16] <= byte_i;
          default: ;
        endcase
        byte_cnt_reg <= byte_cnt_reg + 2'd1;
      end

      if (load_word) begin
        word_reg       <= {byte_i[5:0], partial_reg};
        idx_reg        <= 2'd0;
        sample_valid_o <= 1'b1;
        sample_o       <= partial_reg[9:0];
        trig_word_reg  <= new_trig;
        word_tag_reg   <= in_tag;
        sample_trig_o  <= new_trig & (in_tag == 2'd0);
        if (new_trig) begin
          trig_seen_reg <= 1'b1;
          trig_tag_reg  <= in_tag;
        end
        if ((in_tag != TAG_NONE) && trig_seen_reg && (in_tag != trig_tag_reg))
          tag_err_o <= 1'b1;
      end else if (sample_hs) begin
        if (idx_reg == 2'd2) begin
          idx_reg        <= 2'd0;
          sample_valid_o <= 1'b0;
          sample_o       <= '0;
          sample_trig_o  <= 1'b0;
        end else begin
          idx_reg       <= idx_next;
          sample_o      <= (idx_next == 2'd1) ? word_reg[19:10] : word_reg[29:20];
          sample_trig_o <= trig_word_reg & (idx_next == word_tag_reg);
        end
      end

      if (sample_hs && (sample_count_o != '1))
        sample_count_o <= sample_count_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_adc_sample_unpack.sv
// Directed bench for adc_sample_unpack: hand-computed words, samples, trigger
// markers, backpressure, restart and asynchronous reset behaviour.
module tb_adc_sample_unpack;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        sync;
  logic        drop;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic [9:0]  sample;
  logic        sample_valid;
  logic        sample_ready;
  logic        sample_trig;
  logic [31:0] sample_count;
  logic        tag_err;

  int n_vec = 0;
  int n_err = 0;

  logic [9:0] mon_samp [0:63];
  logic       mon_trig [0:63];
  int         mon_n = 0;
  int         acc_n = 0;

  always #5 clk = ~clk;

  adc_sample_unpack #(.COUNT_W(32), .TAG_NONE(2'b11)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .sync_i         (sync),
    .drop_pretrig_i (drop),
    .byte_i         (byte_in),
    .byte_valid_i   (byte_valid),
    .byte_ready_o   (byte_ready),
    .sample_o       (sample),
    .sample_valid_o (sample_valid),
    .sample_ready_i (sample_ready),
    .sample_trig_o  (sample_trig),
    .sample_count_o (sample_count),
    .tag_err_o      (tag_err)
  );

  // Inputs only change at posedge+2, so the negedge view is what the next edge sees.
  always @(negedge clk) begin
    if (reset_n) begin
      if (sample_valid && sample_ready && mon_n < 64) begin
        mon_samp[mon_n] = sample;
        mon_trig[mon_n] = sample_trig;
        mon_n++;
      end
      if (byte_valid && byte_ready) acc_n++;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit done;
    done = 1'b0;
    byte_in    = b;
    byte_valid = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (byte_ready) done = 1'b1;
      tick();
    end
    byte_valid = 1'b0;
    if (!done) check("byte_accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic do_sync();
    sync = 1'b1;
    tick();
    sync = 1'b0;
  endtask

  task automatic check_samp(input string tag, input int i, input logic [9:0] s, input logic t);
    check($sformatf("%s_samp%0d", tag, i), {54'd0, mon_samp[i]}, {54'd0, s});
    check($sformatf("%s_trig%0d", tag, i), {63'd0, mon_trig[i]}, {63'd0, t});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int base_acc;
    reset_n = 1'b0; sync = 1'b0; drop = 1'b0;
    byte_in = '0; byte_valid = 1'b0; sample_ready = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;

    @(negedge clk);
    check("rst_byte_ready", byte_ready, 1);
    check("rst_valid", sample_valid, 0);
    check("rst_sample", sample, 0);
    check("rst_trig", sample_trig, 0);
    check("rst_count", sample_count, 0);
    check("rst_tag_err", tag_err, 0);
    tick();

    // Plain pre-trigger word, everything passed through.
    sample_ready = 1'b1;
    base = mon_n;
    send_word(32'hC030_0401);
    check("t1_latency_valid", sample_valid, 1);
    check("t1_latency_sample", sample, 10'h001);
    repeat (4) tick();
    check("t1_n", mon_n - base, 3);
    check_samp("t1", base + 0, 10'h001, 1'b0);
    check_samp("t1", base + 1, 10'h001, 1'b0);
    check_samp("t1", base + 2, 10'h003, 1'b0);
    check("t1_count", sample_count, 3);

    // Pre-trigger word dropped; trigger at index 1 of the next word.
    do_sync();
    check("t2_sync_count", sample_count, 0);
    drop = 1'b1;
    base = mon_n;
    send_word(32'hC030_0401);
    check("t2_dropped_valid", sample_valid, 0);
    send_word(32'h4030_0401);
    repeat (4) tick();
    check("t2_n", mon_n - base, 3);
    check_samp("t2", base + 0, 10'h001, 1'b0);
    check_samp("t2", base + 1, 10'h001, 1'b1);
    check_samp("t2", base + 2, 10'h003, 1'b0);
    check("t2_count", sample_count, 3);
    drop = 1'b0;

    // Tag 2 then tag 0: single marker, sticky tag error.
    do_sync();
    base = mon_n;
    send_word(32'h8030_0401);
    check("t3_tag_err_first", tag_err, 0);
    send_word(32'h0030_0401);
    check("t3_tag_err_set", tag_err, 1);
    repeat (4) tick();
    check("t3_n", mon_n - base, 6);
    check_samp("t3", base + 0, 10'h001, 1'b0);
    check_samp("t3", base + 1, 10'h001, 1'b0);
    check_samp("t3", base + 2, 10'h003, 1'b1);
    check_samp("t3", base + 3, 10'h001, 1'b0);
    check_samp("t3", base + 4, 10'h001, 1'b0);
    check_samp("t3", base + 5, 10'h003, 1'b0);
    check("t3_tag_err_hold", tag_err, 1);
    check("t3_count", sample_count, 6);

    // Asynchronous reset while a sample is being presented.
    sample_ready = 1'b0;
    send_word(32'h0030_0401);
    tick();
    check("t6_pre_valid", sample_valid, 1);
    check("t6_pre_sample", sample, 10'h001);
    check("t6_pre_count", sample_count, 6);
    check("t6_pre_tag_err", tag_err, 1);
    #1 reset_n = 1'b0;
    #1;
    check("t6_async_valid", sample_valid, 0);
    check("t6_async_sample", sample, 0);
    check("t6_async_trig", sample_trig, 0);
    check("t6_async_count", sample_count, 0);
    check("t6_async_tag_err", tag_err, 0);
    check("t6_async_byte_ready", byte_ready, 1);
    tick();
    reset_n = 1'b1;
    tick();

    // Backpressure: 7 of 8 bytes accepted, 8th enters as sample2 leaves.
    base_acc = acc_n;
    base = mon_n;
    send_word(32'hC330_8811);
    send_byte(8'h44);
    send_byte(8'h54);
    send_byte(8'h61);
    byte_in = 8'hC6;
    byte_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("t4_hold_ready%0d", k), byte_ready, 0);
      check($sformatf("t4_hold_sample%0d", k), sample, 10'h011);
      check($sformatf("t4_hold_valid%0d", k), sample_valid, 1);
      tick();
    end
    check("t4_accepted7", acc_n - base_acc, 7);
    sample_ready = 1'b1;
    @(negedge clk);
    check("t4_rel0_ready", byte_ready, 0);
    check("t4_rel0_sample", sample, 10'h011);
    tick();
    @(negedge clk);
    check("t4_rel1_ready", byte_ready, 0);
    check("t4_rel1_sample", sample, 10'h022);
    tick();
    @(negedge clk);
    check("t4_rel2_ready", byte_ready, 1);
    check("t4_rel2_sample", sample, 10'h033);
    tick();
    byte_valid = 1'b0;
    @(negedge clk);
    check("t4_nobubble_valid", sample_valid, 1);
    check("t4_nobubble_sample", sample, 10'h044);
    repeat (4) tick();
    check("t4_n", mon_n - base, 6);
    check_samp("t4", base + 0, 10'h011, 1'b0);
    check_samp("t4", base + 1, 10'h022, 1'b0);
    check_samp("t4", base + 2, 10'h033, 1'b0);
    check_samp("t4", base + 3, 10'h044, 1'b0);
    check_samp("t4", base + 4, 10'h055, 1'b0);
    check_samp("t4", base + 5, 10'h066, 1'b0);
    check("t4_accepted8", acc_n - base_acc, 8);
    check("t4_count", sample_count, 6);

    // Restart mid-word: byte offered with sync is not consumed.
    do_sync();
    base_acc = acc_n;
    send_byte(8'hAA);
    send_byte(8'hBB);
    sync = 1'b1;
    byte_in = 8'hCC;
    byte_valid = 1'b1;
    @(negedge clk);
    check("t5_sync_byte_ready", byte_ready, 0);
    tick();
    sync = 1'b0;
    byte_valid = 1'b0;
    check("t5_count", sample_count, 0);
    check("t5_valid", sample_valid, 0);
    base = mon_n;
    send_word(32'hC330_8811);
    repeat (4) tick();
    check("t5_n", mon_n - base, 3);
    check_samp("t5", base + 0, 10'h011, 1'b0);
    check_samp("t5", base + 1, 10'h022, 1'b0);
    check_samp("t5", base + 2, 10'h033, 1'b0);
    check("t5_accepted", acc_n - base_acc, 6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/adc_sample_unpack.md
# adc_sample_unpack

Reader-side unpacker for the capture FIFO byte stream. It consumes the 8-bit stream produced when the 32-bit capture words are drained, and rebuilds each 32-bit word. Each word is then split back into its three 10-bit ADC samples plus the 2-bit trigger-location tag. It sits on the host-side/readback path (e.g. in front of a stream processor or trace buffer) and presents samples on a valid/ready interface with a one-shot trigger marker.

## Interface
- `COUNT_W`, default 32: width of `sample_count_o`.
- `TAG_NONE`, default 2'b11: tag value meaning "pre-trigger word, no trigger location yet".
- `clk` in 1: sole clock; all logic is on its rising edge.
- `reset_n` in 1: reset, asynchronous, active-low.
- `sync_i` in 1: synchronous restart (new capture); clears all state except `COUNT_W`-independent config.
- `drop_pretrig_i` in 1: 1 = discard all samples of words whose tag == `TAG_NONE`.
- `byte_i` in 8: input byte.
- `byte_valid_i` in 1: byte present.
- `byte_ready_o` out 1: unpacker accepts byte this cycle.
- `sample_o` out 10: output sample.
- `sample_valid_o` out 1: sample present.
- `sample_ready_i` in 1: consumer accepts sample.
- `sample_trig_o` out 1: qualifies `sample_o`; high only for the trigger sample.
- `sample_count_o` out `COUNT_W`: samples handed over since restart; saturating.
- `tag_err_o` out 1: sticky; trigger tag changed between two non-`TAG_NONE` values.

## Operation
- Byte transfer occurs when `byte_valid_i & byte_ready_o`. Sample transfer occurs when `sample_valid_o & sample_ready_i`.
- Assembler: 2-bit `byte_cnt`, 24-bit partial register. Bytes arrive little-endian per word: the 1st byte is word[7:0] and the 4th byte is word[31:24].
- Word fields: sample0 = [9:0], sample1 = [19:10], sample2 = [29:20], tag = [31:30].
- Output stage: holds one word plus a 2-bit index `idx` (0→1→2). It is busy while it holds a word.
- On acceptance of the 4th byte, the full word loads into the output stage with `idx` = 0. The exception is when `drop_pretrig_i` = 1 and tag == `TAG_NONE`: the word is discarded, the output stage is not loaded, and `byte_cnt` wraps to 0.
- `byte_ready_o` = (`byte_cnt` != 3) | !busy | (sample handshake with `idx` == 2). This is a combinational path from `sample_ready_i`, which is intended. When a word is loaded in the same cycle that the last sample is taken, no bubble is inserted.
- Each sample handshake advances `idx`. The handshake at `idx` == 2 frees the stage unless it reloads in the same cycle.
- Trigger marker: an internal `trig_seen` flag, cleared by reset or `sync_i`.
  - In the first word loaded with tag != `TAG_NONE` while `trig_seen` = 0, `sample_trig_o` is 1 while `idx` == tag.
  - `trig_seen` sets when that word loads.
  - The stored tag `trig_tag` is recorded at the same time.
- `tag_err_o`: set when a word loads with tag != `TAG_NONE`, `trig_seen` = 1, and tag != `trig_tag`. It holds until reset or `sync_i`.
- `sample_count_o`: +1 per sample handshake, saturates at all-ones.
- `sync_i` takes priority over any handshake in the same cycle. It clears `byte_cnt`, the output stage, `trig_seen`, `trig_tag`, `tag_err_o`, and `sample_count_o`. A byte presented in that cycle is not consumed (`byte_ready_o` = 0 while `sync_i` = 1).

## Timing
- Reset values: `byte_ready_o` = 1 (0 only while `sync_i` = 1); `sample_valid_o` = 0; `sample_o` = 0; `sample_trig_o` = 0; `sample_count_o` = 0; `tag_err_o` = 0.
- Latency: 4th byte accepted at edge N → `sample_valid_o` = 1 with sample0 after edge N; with `sample_ready_i` held high, sample1 and sample2 follow on the next two cycles.
- Sustained rate: 1 byte/cycle in gives 3 samples per 4 cycles out. No input stall occurs when `sample_ready_i` = 1.
- Backpressure: with `sample_ready_i` = 0, the assembler fills to 3 bytes and then deasserts `byte_ready_o`. `sample_o`, `sample_trig_o`, and `sample_valid_o` are held stable until the handshake.
- `sample_o` and `sample_trig_o` are registered outputs derived from the output stage and `idx`. The only combinational output path is `sample_ready_i` → `byte_ready_o`.
- Asynchronous reset mid-word discards the partial bytes. There is no resynchronisation to word boundaries other than reset or `sync_i`.

## Test plan
- Bytes 0x01, 0x04, 0x30, 0xC0 (word 0xC0300401, tag 3) with `drop_pretrig_i` = 0 and ready high → samples 0x001, 0x001, 0x003 on 3 consecutive cycles; `sample_trig_o` always 0; count = 3.
- Word 0xC0300401 then word 0x40300401 (tag 1), `drop_pretrig_i` = 1 → only 3 samples out (0x001, 0x001, 0x003); `sample_trig_o` = 1 on the second of them only; count = 3.
- Two consecutive words with tag 2 then tag 0 → `sample_trig_o` = 1 only on sample2 of the first word; `tag_err_o` rises after the second word loads and stays high.
- `sample_ready_i` = 0 while 8 bytes are offered → exactly 7 bytes accepted; `byte_ready_o` = 0 afterwards; outputs stable. Release ready → 6 samples in order, the 8th byte is accepted in the cycle sample2 of the first word is taken, with no lost data.
- 2 bytes sent, then `sync_i` pulsed together with a valid byte → byte not consumed; count = 0; the next 4 bytes form a fresh word.
- Drive `reset_n` low asynchronously mid-sample-emission → all outputs return to reset values immediately, without waiting for a clock edge.
